// File: rtl/cache_pkg.sv
// Shared definitions for the cache sequencing controller: default geometry,
// derived tag width, word alignment and the controller state encoding.
package cache_pkg;

  localparam int default_addr_width  = 32;
  localparam int default_data_width  = 32;
  localparam int default_idx_size    = 6;
  localparam int default_offset_bits = 2;
  localparam int default_cnt_width   = 16;

  // Tag is whatever remains of the byte address above index and offset.
  localparam int tag_size = default_addr_width - default_idx_size - default_offset_bits;

  // One data word per block: L2 addresses are aligned to this many bytes.
  localparam int word_bytes = 1 << default_offset_bits;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    L2_READ  = 3'd2,
    FILL     = 3'd3,
    L2_WRITE = 3'd4,
    RESPOND  = 3'd5
  } state_t;

endpackage

// File: rtl/cache_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module cache_sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

  // Count enabled events, holding once every bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + one;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Cache sequencing FSM: accepts one CPU load/store at a time, drives the
// array/replacement strobes, runs the L2 handshake for refills and
// write-through stores, and returns load data to the CPU.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a CPU request; request fields latched on accept
// LOOKUP   | tag compare; loads read, stores write the chosen way
// L2_READ  | refill request outstanding to L2
// FILL     | one-cycle array write of the refilled word
// L2_WRITE | write-through store outstanding to L2
// RESPOND  | one-cycle completion pulse to the CPU
module cache_controller
  import cache_pkg::*;
#(
  parameter int addr_width  = default_addr_width,
  parameter int data_width  = default_data_width,
  parameter int idx_size    = default_idx_size,
  parameter int offset_bits = default_offset_bits,
  parameter int cnt_width   = default_cnt_width
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      cpu_req_i,
  input  logic                                      cpu_we_i,
  input  logic [addr_width-1:0]                     cpu_addr_i,
  input  logic [data_width-1:0]                     cpu_wdata_i,
  output logic                                      cpu_ready_o,
  output logic                                      cpu_valid_o,
  output logic [data_width-1:0]                     cpu_rdata_o,
  output logic [idx_size-1:0]                       idx_o,
  output logic [addr_width-idx_size-offset_bits-1:0] tag_o,
  output logic                                      cache_read_o,
  output logic                                      cache_write_o,
  output logic                                      write_L2_o,
  output logic                                      write_through_o,
  output logic [data_width-1:0]                     cache_wdata_o,
  input  logic                                      hit_s1_i,
  input  logic                                      hit_s2_i,
  input  logic [data_width-1:0]                     rdata_s1_i,
  input  logic [data_width-1:0]                     rdata_s2_i,
  output logic                                      l2_req_o,
  output logic                                      l2_we_o,
  output logic [addr_width-1:0]                     l2_addr_o,
  output logic [data_width-1:0]                     l2_wdata_o,
  input  logic                                      l2_ack_i,
  input  logic [data_width-1:0]                     l2_rdata_i,
  output logic [cnt_width-1:0]                      hit_cnt_o,
  output logic [cnt_width-1:0]                      miss_cnt_o
);

  localparam int tag_bits = addr_width - idx_size - offset_bits;

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  hit;
  logic                  hit_inc;
  logic                  miss_inc;
  logic                  req_we;
  logic [tag_bits-1:0]   req_tag;
  logic [idx_size-1:0]   req_idx;
  logic [data_width-1:0] req_wdata;
  logic [data_width-1:0] load_data;

  assign accept = (state == IDLE) && cpu_req_i;
  assign hit    = hit_s1_i | hit_s2_i;

  // State register; reset abandons any transaction so every strobe and the
  // L2 request, all decoded from state, drop while reset is still asserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch: fields are only sampled on accept, so a requester holding
  // cpu_req_i with a changing address cannot disturb a transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
    end else if (accept) begin
      req_we    <= cpu_we_i;
      req_tag   <= cpu_addr_i[addr_width-1 -: tag_bits];
      req_idx   <= cpu_addr_i[offset_bits +: idx_size];
      req_wdata <= cpu_wdata_i;
    end
  end

  // Load data capture: way data on a lookup hit (way 1 wins a double hit),
  // or L2 data on the refill acknowledge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_data <= '0;
    end else if ((state == LOOKUP) && !req_we && hit) begin
      load_data <= hit_s1_i ? rdata_s1_i : rdata_s2_i;
    end else if ((state == L2_READ) && l2_ack_i) begin
      load_data <= l2_rdata_i;
    end
  end

  // Next-state and strobe decode; everything defaults inactive so only the
  // owning state raises a strobe.
  always_comb begin
    state_next      = state;
    cpu_ready_o     = 1'b0;
    cpu_valid_o     = 1'b0;
    cpu_rdata_o     = '0;
    cache_read_o    = 1'b0;
    cache_write_o   = 1'b0;
    write_L2_o      = 1'b0;
    write_through_o = 1'b0;
    cache_wdata_o   = '0;
    l2_req_o        = 1'b0;
    l2_we_o         = 1'b0;
    l2_wdata_o      = '0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;

    case (state)
      IDLE: begin
        cpu_ready_o = 1'b1;
        if (cpu_req_i) begin
          state_next = LOOKUP;
        end
      end

      LOOKUP: begin
        hit_inc  = hit;
        miss_inc = !hit;
        if (req_we) begin
          // Write-allocate: the replacement stage writes the hit way, or the
          // invalid/LRU way on a miss, at the end of this cycle.
          cache_write_o   = 1'b1;
          write_through_o = 1'b1;
          cache_wdata_o   = req_wdata;
          state_next      = L2_WRITE;
        end else begin
          cache_read_o = 1'b1;
          state_next   = hit ? RESPOND : L2_READ;
        end
      end

      L2_READ: begin
        l2_req_o = 1'b1;
        if (l2_ack_i) begin
          state_next = FILL;
        end
      end

      FILL: begin
        cache_write_o = 1'b1;
        write_L2_o    = 1'b1;
        cache_wdata_o = load_data;
        state_next    = RESPOND;
      end

      L2_WRITE: begin
        l2_req_o   = 1'b1;
        l2_we_o    = 1'b1;
        l2_wdata_o = req_wdata;
        if (l2_ack_i) begin
          state_next = RESPOND;
        end
      end

      RESPOND: begin
        cpu_valid_o = 1'b1;
        cpu_rdata_o = req_we ? '0 : load_data;
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign idx_o     = req_idx;
  assign tag_o     = req_tag;
  // Built from latched fields only, so it is stable for the whole request.
  assign l2_addr_o = {req_tag, req_idx, {offset_bits{1'b0}}};

  cache_sat_counter #(
    .width(cnt_width)
  ) u_hit_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .clear(1'b0),
    .en   (hit_inc),
    .count(hit_cnt_o)
  );

  cache_sat_counter #(
    .width(cnt_width)
  ) u_miss_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .clear(1'b0),
    .en   (miss_inc),
    .count(miss_cnt_o)
  );

endmodule
